sc_sobol_mul_seq: RTL
=====================

// Module: sc_sobol_mul_seq
// PURPOSE
//   Sequential multi-channel stochastic-computing multiplier for the SC CGRA PE.
//   Generates the a-stream against a Gray-code Sobol (dim-1) sequence and the b-stream against a ramp.
//   Counts ones of (a_bs & b_bs) over one 2^LOG_LEN-bit period and returns binary products.
//   NUM_CH channels share one sequence generator; valid/ready on both sides.
// PARAMETERS
//   LOG_LEN  5  log2 of bitstream length; LEN = 2^LOG_LEN cycles per product
//   IN_W     6  operand width (>= LOG_LEN+1); unary scale: value LEN == 1.0
//   NUM_CH   4  independent multiplier channels sharing one sequence generator
// PORTS
//   clk        in   1                  clock, rising edge
//   rst_n      in   1                  asynchronous active-low reset
//   in_valid   in   1                  operand set valid
//   in_ready   out  1                  block can accept operands
//   a          in   NUM_CH*IN_W        operand a, channel k at [k*IN_W +: IN_W]
//   b          in   NUM_CH*IN_W        operand b, same packing
//   out_valid  out  1                  products valid
//   out_ready  in   1                  consumer accepts products
//   prod       out  NUM_CH*(LOG_LEN+1) ones count per channel, channel k at [k*(LOG_LEN+1) +: LOG_LEN+1]
// BEHAVIOUR
//   - Reset values: in_ready=1, out_valid=0, prod=0; FSM=IDLE, idx=0, sob=0.
//   - FSM states:
//     IDLE -(in_valid)-> RUN: latch a/b, clear accumulators, idx=0, sob=0.
//     RUN: one bit per cycle; after the idx==LEN-1 evaluation -> DONE.
//     DONE -(out_ready)-> IDLE.
//   - in_ready=1 only in IDLE. out_valid=1 only in DONE.
//   - prod is registered and held stable while out_valid=1 && !out_ready.
//   - RUN cycle: acc[k] += (a[k] > sob) & (b[k] > idx), with compares unsigned and zero-extended to IN_W.
//   - Sobol update: sob_next = sob ^ v[c], where c = index of the lowest 0 bit of idx.
//     Direction vectors: v[c] = 1 << (LOG_LEN-1-c).
//     LOG_LEN=5 sequence: 0,16,24,8,12,28,20,4,6,22,...,17,1.
//   - idx wraps LEN-1 -> 0 on leaving RUN; no carry into other state.
//   - Latency: out_valid rises exactly LEN cycles after the in_valid&in_ready edge.
//     Next acceptance is possible the cycle after the out handshake (LEN+2 cycles per op minimum).
//   - Widths: acc is LOG_LEN+1 bits; max count LEN never overflows.
//     Operands >= LEN saturate naturally (stream all ones).
//   - Operand 0 gives a stream of all zeros; the product is 0.
//   - in_valid while busy: ignored (in_ready=0); operands are not re-sampled.
//   - rst_n low mid-RUN or mid-DONE: immediate abort to reset values; the pending result is lost.
// CONFIGURATION
//   SC_BITSTREAM_OUT_EN defined: adds these ports.
//     bs_valid  out  1       high in each RUN cycle
//     bs_out    out  NUM_CH  combinational a_bs & b_bs of the current cycle
//     bs_valid/bs_out reset to 0 and are 0 outside RUN.
//   Not defined: these ports do not exist and the logic is removed; prod behaviour is unchanged.
// STRUCTURE
//   Package sc_pkg holds:
//     sc_state_e {IDLE,RUN,DONE}
//     function sobol_dir(c, LOG_LEN) returning v[c]
//     function lowest_zero(idx)
//   Sub-module sc_sobol_seq_gen (clk, rst_n, clr, step -> idx, sob, last) holds the shared counter and Sobol state.
//   Top level holds the FSM, operand registers, NUM_CH accumulators and the output register.
// TESTING
//   1. Defaults, ch0 a=32,b=16 / ch1 a=0,b=32 / ch2 a=16,b=32 / ch3 a=16,b=16
//      -> prod={8,16,0,16} (ch3..ch0); out_valid exactly 32 cycles after accept.
//   2. a=63,b=63 all channels -> prod=32 each (saturation; no overflow).
//   3. Hold out_ready=0 for 10 cycles in DONE
//      -> prod/out_valid stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
//   4. Assert rst_n=0 at RUN cycle 12 -> out_valid=0, prod=0, in_ready=1 at once.
//      New op after release -> correct result.
//   5. Back-to-back ops with out_ready=1, in_valid=1 held -> one result per 34 cycles.
//      Second op uses freshly latched operands.
//   6. SC_BITSTREAM_OUT_EN, LOG_LEN=3
//      -> sob order 0,4,6,2,3,7,5,1; bs_out popcount equals prod; bs_valid high 8 cycles.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing Sobol multiplier.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sc_state_e;

    // Index of the lowest zero bit; 32 when every bit is set.
    function automatic int unsigned lowest_zero(input logic [31:0] idx);
        int unsigned c;
        c = 32;
        for (int i = 31; i >= 0; i--) begin
            if (!idx[i]) c = i;
        end
        return c;
    endfunction

    // Dimension-1 Sobol direction vector. Out-of-range c yields 0, so the
    // all-ones index at the end of a period leaves the sequence unchanged.
    function automatic logic [31:0] sobol_dir(input int unsigned c, input int unsigned log_len);
        if (c < log_len) return 32'd1 << (log_len - 1 - c);
        return 32'd0;
    endfunction

endpackage

// File: rtl/sc_sobol_seq_gen.sv
// Shared bit-index counter and Gray-code Sobol sequence generator.
module sc_sobol_seq_gen
    import sc_pkg::*;
#(
    parameter int LOG_LEN = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               step,
    output logic [LOG_LEN-1:0] idx,
    output logic [LOG_LEN-1:0] sob,
    output logic               last
);

    logic [LOG_LEN-1:0] idx_q, idx_d;
    logic [LOG_LEN-1:0] sob_q, sob_d;

    // Next index/Sobol point: clear on a new operation, advance one bit per step.
    always_comb begin
        idx_d = idx_q;
        sob_d = sob_q;
        if (clr) begin
            idx_d = '0;
            sob_d = '0;
        end else if (step) begin
            idx_d = idx_q + 1'b1;
            sob_d = sob_q ^ LOG_LEN'(sobol_dir(lowest_zero(32'(idx_q)), LOG_LEN));
        end
    end

    // Sequence state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            sob_q <= '0;
        end else begin
            idx_q <= idx_d;
            sob_q <= sob_d;
        end
    end

    assign idx  = idx_q;
    assign sob  = sob_q;
    assign last = (idx_q == '1);

endmodule

// File: rtl/sc_sobol_mul_seq.sv
// Sequential multi-channel stochastic-computing multiplier.
// a-streams compare against a Gray-code Sobol sequence, b-streams against a
// ramp; the product is the ones count of a_bs & b_bs over 2^LOG_LEN cycles.
// Optional macro SC_BITSTREAM_OUT_EN exposes the per-cycle product bits.
module sc_sobol_mul_seq
    import sc_pkg::*;
#(
    parameter int LOG_LEN = 5,
    parameter int IN_W    = 6,
    parameter int NUM_CH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*IN_W-1:0]        a,
    input  logic [NUM_CH*IN_W-1:0]        b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*(LOG_LEN+1)-1:0] prod
`ifdef SC_BITSTREAM_OUT_EN
    ,
    output logic                          bs_valid,
    output logic [NUM_CH-1:0]             bs_out
`endif
);

    localparam int PW = LOG_LEN + 1;

    sc_state_e state_q, state_d;
    logic accept, step, last;
    logic [LOG_LEN-1:0] idx, sob;
    logic [NUM_CH*IN_W-1:0] a_q, b_q;
    logic [NUM_CH-1:0][PW-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0][PW-1:0] prod_q, prod_d;
    logic [NUM_CH-1:0] hit;

    sc_sobol_seq_gen #(.LOG_LEN(LOG_LEN)) u_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .step  (step),
        .idx   (idx),
        .sob   (sob),
        .last  (last)
    );

    // FSM next state: accept in IDLE, one bit per RUN cycle, wait for consumer in DONE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Product bits and accumulator/result next values for every channel.
    always_comb begin
        acc_d  = acc_q;
        prod_d = prod_q;
        hit    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            hit[k] = (a_q[k*IN_W +: IN_W] > IN_W'(sob)) && (b_q[k*IN_W +: IN_W] > IN_W'(idx));
            if (accept) acc_d[k] = '0;
            else if (step) acc_d[k] = acc_q[k] + PW'(hit[k]);
        end
        if (state_q == RUN && last) prod_d = acc_d;
    end

    // Control state and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
        end
    end

    // Operand latches and accumulators; always initialised by an accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
        acc_q <= acc_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign prod      = prod_q;

`ifdef SC_BITSTREAM_OUT_EN
    assign bs_valid = (state_q == RUN);
    assign bs_out   = (state_q == RUN) ? hit : '0;
`endif

endmodule
